// File: rtl/vram_arbiter.sv
// Shares a 1-cycle-latency pixel RAM between VGA scan-out reads and two round-robin writers.
// Latency: p_tick -> RD on the port 1 cycle, -> pix_valid 3 cycles; uncontended req -> gnt/write 1 cycle.
// Backpressure: writers stall with req held while a read takes the slot. VRAM_ARB_WRITE_BLANK_ONLY_EN confines writes to blanking.
module vram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1
);

    typedef enum logic [1:0] {IDLE, RD, WR0, WR1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   pix_data_q;
    logic                pix_valid_q;
    logic                last_q;
    logic                tick1_q, tick2_q;
    logic                flag1_q, flag2_q;
    logic                wr_ok, elig0, elig1;
    logic [ADDR_W-1:0]   x_ext, y_ext, rd_addr;

    assign x_ext   = ADDR_W'(x);
    assign y_ext   = ADDR_W'(y);
    assign rd_addr = (y_ext << 9) + (y_ext << 7) + x_ext;

`ifdef VRAM_ARB_WRITE_BLANK_ONLY_EN
    assign wr_ok = ~video_on;
`else
    assign wr_ok = 1'b1;
`endif

    // A writer granted this cycle still holds req; skip it so it is not granted twice.
    assign elig0 = req0 && (state_q != WR0) && wr_ok;
    assign elig1 = req1 && (state_q != WR1) && wr_ok;

    always_comb begin
        state_d = IDLE;
        if (p_tick && video_on)
            state_d = RD;
        else if (elig0 && elig1)
            state_d = last_q ? WR0 : WR1;
        else if (elig0)
            state_d = WR0;
        else if (elig1)
            state_d = WR1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_q      <= 1'b1;
            tick1_q     <= 1'b0;
            tick2_q     <= 1'b0;
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_d)
                RD: mem_addr_q <= rd_addr;
                WR0: begin
                    mem_addr_q  <= addr0;
                    mem_wdata_q <= wdata0;
                    last_q      <= 1'b0;
                end
                WR1: begin
                    mem_addr_q  <= addr1;
                    mem_wdata_q <= wdata1;
                    last_q      <= 1'b1;
                end
                default: ;
            endcase
            // Read data lands two cycles after the tick; register it on the third.
            tick1_q     <= p_tick;
            flag1_q     <= p_tick && video_on;
            tick2_q     <= tick1_q;
            flag2_q     <= flag1_q;
            pix_valid_q <= tick2_q;
            if (tick2_q)
                pix_data_q <= flag2_q ? rd_data : '0;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign gnt0      = (state_q == WR0);
    assign gnt1      = (state_q == WR1);
    assign mem_we    = gnt0 | gnt1;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected writes/pixels with cycle stamps, a negedge monitor retires them.
module tb_vram_arbiter;
    localparam int AW = 19;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset, p_tick, video_on;
    logic [9:0]    x, y;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, pix_data;
    logic          pix_valid;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1)
    );

    typedef struct { int id; int addr; int data; int cyc; } wr_t;
    typedef struct { int data; int cyc; } px_t;
    wr_t wq[$];
    px_t pq[$];
    wr_t we_exp;
    px_t px_exp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int phase = 0;
    bit tick_en = 0;
    bit force_fff = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory stand-in: read data is a fixed function of the address.
    always @(posedge clk) rd_data <= force_fff ? 12'hFFF : (mem_addr[11:0] ^ 12'h5A5);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we || gnt0 || gnt1) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %0d gnt %0d%0d at cycle %0d, expected none",
                         mem_addr, mem_wdata, gnt1, gnt0, cyc);
            end else begin
                we_exp = wq.pop_front();
                check("wr_cycle", cyc, we_exp.cyc);
                check("wr_addr", mem_addr, we_exp.addr);
                check("wr_data", mem_wdata, we_exp.data);
                check("wr_gnt", {gnt1, gnt0}, (we_exp.id == 0) ? 1 : 2);
                check("wr_we", mem_we, 1);
            end
        end
        if (pix_valid) begin
            if (pq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pix: got data %0d at cycle %0d, expected none", pix_data, cyc);
            end else begin
                px_exp = pq.pop_front();
                check("pix_cycle", cyc, px_exp.cyc);
                check("pix_data", pix_data, px_exp.data);
            end
        end
    end

    // Applies the current inputs for one cycle; p_tick comes from the bench's 1-in-4 phase.
    task automatic step();
        int a;
        p_tick = tick_en && (phase == 0);
        if (p_tick) begin
            a = y * 640 + x;
            if (video_on) pq.push_back('{(a & 'hFFF) ^ 'h5A5, cyc + 3});
            else          pq.push_back('{0, cyc + 3});
        end
        @(posedge clk);
        #1;
        if (p_tick) x = x + 10'd1;
        phase = (phase + 1) % 4;
    endtask

    initial begin
        int c, n0, n1, saved, q;
        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) step();
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_gnt", {gnt1, gnt0}, 0);
        reset = 1'b1;
        step();

        // Both writers held in blanking: grants alternate every cycle, writer 0 first.
        force_fff = 1'b1; tick_en = 1'b1; phase = 1; video_on = 1'b0;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            wq.push_back('{0, 1000 + k, 'h100 + k, c + 1 + 2 * k});
            wq.push_back('{1, 2000 + k, 'h200 + k, c + 2 + 2 * k});
        end
        for (int t = 0; t < 8; t++) begin
            n0 = (t >= 2) ? t / 2 : 0;
            n1 = (t >= 3) ? (t - 1) / 2 : 0;
            req0 = 1'b1; addr0 = AW'(1000 + n0); wdata0 = DW'('h100 + n0);
            req1 = 1'b1; addr1 = AW'(2000 + n1); wdata1 = DW'('h200 + n1);
            step();
        end
        req0 = 1'b0;
        step();
        req1 = 1'b0;
        repeat (3) step();

        // Blanking ticks issue no reads.
        saved = mem_addr;
        phase = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("blank_no_rd_addr", mem_addr, saved);
            check("blank_no_rd_we", mem_we, 0);
            repeat (3) step();
        end
        force_fff = 1'b0;

        // Active video, no requests: RD at y*640+x one cycle after each tick.
        video_on = 1'b1; y = 10'd2; x = 10'd3; phase = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rd_addr", mem_addr, 1283 + i);
            check("rd_we", mem_we, 0);
            repeat (3) step();
        end

        // req0 aligned with a tick: RD first, then a single grant.
        c = cyc;
        req0 = 1'b1; addr0 = AW'(5000); wdata0 = 12'hABC;
        wq.push_back('{0, 5000, 'hABC, c + 2});
        step();
        check("tick_rd_wins_addr", mem_addr, 1287);
        check("tick_rd_wins_gnt", gnt0, 0);
        step();
        step();
        req0 = 1'b0;
        repeat (6) step();

        // req1 raised mid-line at x=100.
        while (phase != 1) step();
        x = 10'd100;
        req1 = 1'b1; addr1 = AW'(7777); wdata1 = 12'h321;
`ifdef VRAM_ARB_WRITE_BLANK_ONLY_EN
        repeat (9) begin
            step();
            check("blank_only_no_gnt1", gnt1, 0);
        end
        video_on = 1'b0;
        wq.push_back('{1, 7777, 'h321, cyc + 1});
        step();
        step();
        req1 = 1'b0;
        repeat (4) step();
`else
        wq.push_back('{1, 7777, 'h321, cyc + 1});
        step();
        step();
        req1 = 1'b0;
        repeat (4) step();
        video_on = 1'b0;
`endif

        // Reset sampled together with req0: grant dropped, re-issued after release.
        tick_en = 1'b0;
        repeat (5) step();
        req0 = 1'b1; addr0 = AW'(321); wdata0 = 12'h0F0;
        reset = 1'b0;
        step();
        check("rst_mid_gnt0", gnt0, 0);
        check("rst_mid_we", mem_we, 0);
        step();
        reset = 1'b1;
        q = cyc;
        wq.push_back('{0, 321, 'h0F0, q + 1});
        step();
        step();
        req0 = 1'b0;
        repeat (5) step();

        check("wr_queue_drained", wq.size(), 0);
        check("pix_queue_drained", pq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
